// File: rtl/apb_master_param.sv
// Parametrised APB4 requester: one valid/ready command in, one SETUP/ACCESS transfer out, one response back.
// Optional PREADY wait-state timeout is compiled in when APB_MASTER_TIMEOUT_EN is defined.
module apb_master_param #(
  parameter int unsigned             ADDR_WIDTH     = 9,
  parameter int unsigned             DATA_WIDTH     = 8,
  parameter logic [ADDR_WIDTH-1:0]   ADDR_LIMIT     = 'h03F,
  parameter int unsigned             TIMEOUT_CYCLES = 16
) (
  input  logic                      PCLK,
  input  logic                      PRESETn,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0]   cmd_strb,
  output logic                      rsp_valid,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
  output logic                      rsp_err,
  output logic                      rsp_timeout,
  output logic                      PSEL,
  output logic                      PENABLE,
  output logic                      PWRITE,
  output logic [ADDR_WIDTH-1:0]     PADDR,
  output logic [DATA_WIDTH-1:0]     PWDATA,
  output logic [DATA_WIDTH/8-1:0]   PSTRB,
  input  logic                      PREADY,
  input  logic                      PSLVERR,
  input  logic [DATA_WIDTH-1:0]     PRDATA
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  // Reject illegal parameterisations at elaboration instead of building a broken bus.
  if (DATA_WIDTH == 0 || DATA_WIDTH % 8 != 0 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_params
    $error("apb_master_param: DATA_WIDTH must be a non-zero multiple of 8 and TIMEOUT_CYCLES in 1..255");
  end

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

  state_t                  state, state_n;
  logic                    cmd_ready_n, rsp_valid_n, rsp_err_n, rsp_timeout_n;
  logic                    psel_n, penable_n, pwrite_n;
  logic [ADDR_WIDTH-1:0]   paddr_n;
  logic [DATA_WIDTH-1:0]   pwdata_n, rsp_rdata_n;
  logic [STRB_WIDTH-1:0]   pstrb_n;
  logic                    finish;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] wait_cnt, wait_cnt_n;
`endif

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_n       = state;
    cmd_ready_n   = cmd_ready;
    rsp_valid_n   = 1'b0;
    rsp_rdata_n   = rsp_rdata;
    rsp_err_n     = rsp_err;
    rsp_timeout_n = rsp_timeout;
    psel_n        = PSEL;
    penable_n     = PENABLE;
    pwrite_n      = PWRITE;
    paddr_n       = PADDR;
    pwdata_n      = PWDATA;
    pstrb_n       = PSTRB;
    finish        = 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
    wait_cnt_n    = wait_cnt;
`endif
    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          cmd_ready_n   = 1'b0;
          rsp_err_n     = 1'b0;
          rsp_timeout_n = 1'b0;
          if (cmd_addr > ADDR_LIMIT) begin
            state_n     = S_RESP;
            rsp_valid_n = 1'b1;
            rsp_err_n   = 1'b1;
          end else begin
            state_n  = S_SETUP;
            psel_n   = 1'b1;
            pwrite_n = cmd_write;
            paddr_n  = cmd_addr;
            pwdata_n = cmd_write ? cmd_wdata : '0;
            pstrb_n  = cmd_write ? cmd_strb : '0;
          end
        end
      end
      S_SETUP: begin
        state_n   = S_ACCESS;
        penable_n = 1'b1;
`ifdef APB_MASTER_TIMEOUT_EN
        wait_cnt_n = '0;
`endif
      end
      S_ACCESS: begin
        if (PREADY) begin
          finish    = 1'b1;
          rsp_err_n = PSLVERR;
          if (!PWRITE) rsp_rdata_n = PRDATA;
        end
`ifdef APB_MASTER_TIMEOUT_EN
        else if (wait_cnt == WAIT_LAST) begin
          finish        = 1'b1;
          rsp_err_n     = 1'b1;
          rsp_timeout_n = 1'b1;
        end else begin
          wait_cnt_n = wait_cnt + 8'd1;
        end
`endif
      end
      S_RESP: begin
        state_n       = S_IDLE;
        cmd_ready_n   = 1'b1;
        rsp_err_n     = 1'b0;
        rsp_timeout_n = 1'b0;
      end
      default: state_n = S_IDLE;
    endcase

    // Closing a bus transfer: drop the bus back to all-zero and raise the response pulse.
    if (finish) begin
      state_n     = S_RESP;
      rsp_valid_n = 1'b1;
      psel_n      = 1'b0;
      penable_n   = 1'b0;
      pwrite_n    = 1'b0;
      paddr_n     = '0;
      pwdata_n    = '0;
      pstrb_n     = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state       <= S_IDLE;
      cmd_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      PWRITE      <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= '0;
      PSTRB       <= '0;
`ifdef APB_MASTER_TIMEOUT_EN
      wait_cnt    <= '0;
`endif
    end else begin
      state       <= state_n;
      cmd_ready   <= cmd_ready_n;
      rsp_valid   <= rsp_valid_n;
      rsp_rdata   <= rsp_rdata_n;
      rsp_err     <= rsp_err_n;
      rsp_timeout <= rsp_timeout_n;
      PSEL        <= psel_n;
      PENABLE     <= penable_n;
      PWRITE      <= pwrite_n;
      PADDR       <= paddr_n;
      PWDATA      <= pwdata_n;
      PSTRB       <= pstrb_n;
`ifdef APB_MASTER_TIMEOUT_EN
      wait_cnt    <= wait_cnt_n;
`endif
    end
  end

endmodule

// File: tb/tb_apb_master_param.sv
// Self-checking bench for apb_master_param: the bench plays the APB completer and predicts
// every response from the command, the chosen wait states and the error/timeout rules.
module tb_apb_master_param;

  localparam int AW = 9;
  localparam int DW = 8;
  localparam int SW = DW / 8;
  localparam int TO = 4;
  localparam logic [AW-1:0] LIMIT = 9'h03F;

  logic          PCLK = 1'b0;
  logic          PRESETn;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [SW-1:0] cmd_strb;
  logic          rsp_valid, rsp_err, rsp_timeout;
  logic [DW-1:0] rsp_rdata;
  logic          PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA, PRDATA;
  logic [SW-1:0] PSTRB;

  int checks   = 0;
  int failures = 0;
  logic [DW-1:0] exp_rdata;   // last read data the model expects on rsp_rdata

  apb_master_param #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ADDR_LIMIT(LIMIT), .TIMEOUT_CYCLES(TO)
  ) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PREADY(PREADY), .PSLVERR(PSLVERR), .PRDATA(PRDATA)
  );

  always #5 PCLK = ~PCLK;

  // One command end to end. waits = PREADY-low ACCESS cycles the completer wants to insert.
  task automatic do_cmd(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                        input logic [SW-1:0] strb, input int waits, input logic slverr,
                        input logic [DW-1:0] rdata, input logic noise);
    logic [AW+DW+SW:0] exp_bus;
    logic [DW-1:0]     ewd;
    logic [SW-1:0]     estb;
    logic              timed_out;
    int                n_access;
    ewd  = wr ? wdata : '0;
    estb = wr ? strb : '0;
    exp_bus = {wr, addr, ewd, estb};
`ifdef APB_MASTER_TIMEOUT_EN
    timed_out = (waits >= TO);
`else
    timed_out = 1'b0;
`endif
    n_access = timed_out ? TO : waits + 1;

    @(posedge PCLK); #1;
    checks++;
    if (cmd_ready !== 1'b1)
      $display("FAIL cmd_ready_idle: got %b expected 1", cmd_ready);
    if (cmd_ready !== 1'b1) failures++;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_strb = strb;
    @(posedge PCLK); #1;
    // Keep requesting while busy: the block must not take a second command.
    cmd_valid = noise;
    if (noise) begin
      cmd_addr  = AW'($urandom_range(0, 'h3F));
      cmd_wdata = DW'($urandom);
    end

    if (addr > LIMIT) begin
      cmd_valid = 1'b0;
      checks++;
      if ({rsp_valid, rsp_err, rsp_timeout, PSEL, PENABLE, cmd_ready, rsp_rdata} !== {6'b110000, exp_rdata}) begin
        failures++;
        $display("FAIL range_rsp addr=%h: got v/e/t/sel/en/rdy=%b%b%b%b%b%b rdata=%h expected 110000 rdata=%h",
                 addr, rsp_valid, rsp_err, rsp_timeout, PSEL, PENABLE, cmd_ready, rsp_rdata, exp_rdata);
      end
    end else begin
      // Completer noise during SETUP must be ignored.
      PREADY = 1'($urandom_range(0, 1)); PSLVERR = 1'($urandom_range(0, 1)); PRDATA = DW'($urandom);
      checks++;
      if ({PSEL, PENABLE, rsp_valid, cmd_ready} !== 4'b1000 || {PWRITE, PADDR, PWDATA, PSTRB} !== exp_bus) begin
        failures++;
        $display("FAIL setup addr=%h: got sel/en/v/rdy=%b%b%b%b bus=%h expected 1000 bus=%h",
                 addr, PSEL, PENABLE, rsp_valid, cmd_ready, {PWRITE, PADDR, PWDATA, PSTRB}, exp_bus);
      end
      for (int k = 0; k < n_access; k++) begin
        @(posedge PCLK); #1;
        PREADY  = (!timed_out && k == waits);
        PSLVERR = PREADY ? slverr : 1'($urandom_range(0, 1));
        PRDATA  = PREADY ? rdata : DW'($urandom);
        checks++;
        if ({PSEL, PENABLE, rsp_valid, cmd_ready} !== 4'b1100 || {PWRITE, PADDR, PWDATA, PSTRB} !== exp_bus) begin
          failures++;
          $display("FAIL access%0d addr=%h: got sel/en/v/rdy=%b%b%b%b bus=%h expected 1100 bus=%h",
                   k, addr, PSEL, PENABLE, rsp_valid, cmd_ready, {PWRITE, PADDR, PWDATA, PSTRB}, exp_bus);
        end
      end
      @(posedge PCLK); #1;
      cmd_valid = 1'b0; PREADY = 1'b0; PSLVERR = 1'b0;
      if (!wr && !timed_out) exp_rdata = rdata;
      checks++;
      if ({rsp_valid, rsp_err, rsp_timeout, cmd_ready} !== {1'b1, slverr | timed_out, timed_out, 1'b0} ||
          {PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB} !== '0 || rsp_rdata !== exp_rdata) begin
        failures++;
        $display("FAIL response addr=%h: got v/e/t/rdy=%b%b%b%b bus=%h rdata=%h expected %b%b%b0 bus=0 rdata=%h",
                 addr, rsp_valid, rsp_err, rsp_timeout, cmd_ready,
                 {PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB}, rsp_rdata,
                 1'b1, slverr | timed_out, timed_out, exp_rdata);
      end
    end

    @(posedge PCLK); #1;
    checks++;
    if ({rsp_valid, rsp_err, rsp_timeout, cmd_ready, PSEL} !== 5'b00010) begin
      failures++;
      $display("FAIL after_rsp addr=%h: got v/e/t/rdy/sel=%b%b%b%b%b expected 00010",
               addr, rsp_valid, rsp_err, rsp_timeout, cmd_ready, PSEL);
    end
  endtask

  task automatic test_reset();
    PRESETn = 1'b0;
    cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0; cmd_strb = '0;
    PREADY = 0; PSLVERR = 0; PRDATA = '0;
    exp_rdata = '0;
    repeat (3) @(posedge PCLK);
    #1;
    checks++;
    if ({rsp_valid, rsp_err, rsp_timeout, rsp_rdata, PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got %h expected 0",
               {rsp_valid, rsp_err, rsp_timeout, rsp_rdata, PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB});
    end
    PRESETn = 1'b1;
    @(posedge PCLK); #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready: got %b expected 1", cmd_ready);
    end
  endtask

  task automatic test_directed();
    do_cmd(1'b1, 9'h010, 8'hA5, 1'b1, 0, 1'b0, 8'h00, 1'b0);  // zero-wait write
    do_cmd(1'b0, 9'h020, 8'hFF, 1'b1, 2, 1'b0, 8'h3C, 1'b1);  // read, two wait states
    do_cmd(1'b0, 9'h040, 8'h00, 1'b0, 0, 1'b0, 8'h00, 1'b0);  // just above the limit
    do_cmd(1'b0, 9'h03F, 8'h00, 1'b0, 1, 1'b0, 8'h5A, 1'b0);  // exactly the limit
    do_cmd(1'b1, 9'h1FF, 8'h11, 1'b1, 0, 1'b0, 8'h00, 1'b1);  // top of address space
  endtask

  task automatic test_slverr();
    do_cmd(1'b1, 9'h008, 8'h77, 1'b1, 1, 1'b1, 8'h00, 1'b0);
    do_cmd(1'b0, 9'h008, 8'h00, 1'b0, 0, 1'b0, 8'hC3, 1'b0);
    do_cmd(1'b0, 9'h00C, 8'h00, 1'b0, 0, 1'b1, 8'h96, 1'b0);  // erroring read still returns data
  endtask

  task automatic test_timeout();
    // Timeout build: abandoned after TO wait states. Otherwise: completes after a long stall.
    do_cmd(1'b0, 9'h030, 8'h00, 1'b0, 20, 1'b0, 8'hE1, 1'b0);
    do_cmd(1'b0, 9'h031, 8'h00, 1'b0, TO - 1, 1'b0, 8'h4B, 1'b0);  // ready on the limit cycle
    do_cmd(1'b1, 9'h032, 8'h22, 1'b1, 0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      do_cmd(1'($urandom_range(0, 1)), AW'($urandom_range(0, 'h5F)), DW'($urandom),
             SW'($urandom_range(0, 1)), $urandom_range(0, 3), ($urandom_range(0, 3) == 0),
             DW'($urandom), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_reset_in_access();
    @(posedge PCLK); #1;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 9'h015;
    @(posedge PCLK); #1;
    cmd_valid = 1'b0; PREADY = 1'b0;
    repeat (2) @(posedge PCLK);
    #2;
    PRESETn = 1'b0;
    #1;
    exp_rdata = '0;
    checks++;
    if ({rsp_valid, rsp_err, rsp_timeout, rsp_rdata, PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB} !== '0) begin
      failures++;
      $display("FAIL reset_in_access: got %h expected 0",
               {rsp_valid, rsp_err, rsp_timeout, rsp_rdata, PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB});
    end
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge PCLK); #1;
      checks++;
      if ({rsp_valid, PSEL, cmd_ready} !== 3'b001) begin
        failures++;
        $display("FAIL post_reset_idle%0d: got v/sel/rdy=%b%b%b expected 001", k, rsp_valid, PSEL, cmd_ready);
      end
    end
    do_cmd(1'b0, 9'h015, 8'h00, 1'b0, 1, 1'b0, 8'h81, 1'b0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_slverr();
    test_timeout();
    test_random();
    test_reset_in_access();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/apb_master_param.md
# apb_master_param

Parametrised APB4 requester that converts a simple valid/ready command interface into APB SETUP/ACCESS transfers. It sits between a local controller and the APB peripheral bus and returns one response (read data, error, timeout) per command. It generalises the single-width master with configurable address/data width, byte strobes, address-range checking in the request path and an optional PREADY timeout.

## Interface
- ADDR_WIDTH, 9: PADDR / cmd_addr width.
- DATA_WIDTH, 8: data width; must be a multiple of 8; STRB_WIDTH = DATA_WIDTH/8.
- ADDR_LIMIT, 'h03F: highest legal address; commands above it are rejected without an APB transfer.
- TIMEOUT_CYCLES, 16: wait-state limit in ACCESS (timeout build only); legal range 1..255.
- PCLK  in  1  bus clock; all logic on rising edge.
- PRESETn  in  1  reset, asynchronous assert, active-low.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at a PCLK edge.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  target address.
- cmd_wdata  in  DATA_WIDTH  write data.
- cmd_strb  in  STRB_WIDTH  write byte enables.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  DATA_WIDTH  read data; updated only on successful-or-erroring read completion.
- rsp_err  out  1  PSLVERR, range error or timeout for this response.
- rsp_timeout  out  1  response caused by timeout.
- PSEL, PENABLE, PWRITE  out  1  APB control.
- PADDR  out  ADDR_WIDTH; PWDATA  out  DATA_WIDTH; PSTRB  out  STRB_WIDTH.
- PREADY, PSLVERR  in  1; PRDATA  in  DATA_WIDTH.

## Operation
- States: IDLE, SETUP, ACCESS, RESP. All outputs registered.
- IDLE: cmd_ready=1. On accept, latch write/addr/wdata/strb. If cmd_addr > ADDR_LIMIT -> RESP with rsp_err=1, no PSEL. Else -> SETUP.
- SETUP: PSEL=1, PENABLE=0, PADDR/PWRITE/PWDATA/PSTRB driven from latched command -> ACCESS.
- ACCESS: PSEL=1, PENABLE=1. PREADY=1 -> sample PSLVERR into rsp_err; on read sample PRDATA into rsp_rdata; -> RESP. PREADY=0 -> stay (wait state).
- RESP: PSEL=PENABLE=0, rsp_valid=1 for exactly one cycle -> IDLE. rsp_err/rsp_timeout valid only with rsp_valid.
- Reads: PWDATA=0, PSTRB=0 (APB4). Writes: rsp_rdata unchanged.
- PADDR, PWRITE, PWDATA, PSTRB stable from SETUP through final ACCESS cycle; return to 0 in RESP/IDLE.
- Commands presented outside IDLE are not accepted (cmd_ready=0); no queueing.

## Timing
- Reset (async, any state): state IDLE, cmd_ready=1 after release, all other outputs 0 (PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, rsp_*). In-flight transfer dropped, no response issued.
- Accept at edge N: SETUP in cycle N+1, ACCESS from N+2; zero-wait PREADY -> rsp_valid in cycle N+3, cmd_ready again in N+4. Minimum 4 cycles per command; each wait state adds 1.
- Range error: accept at edge N -> rsp_valid in cycle N+1 with rsp_err=1, PSEL never asserted.
- PREADY/PSLVERR/PRDATA ignored outside ACCESS.

## Configuration
- APB_MASTER_TIMEOUT_EN defined: 8-bit wait counter cleared on entering ACCESS, increments each ACCESS cycle with PREADY=0. When it reaches TIMEOUT_CYCLES with PREADY still 0, transfer is abandoned -> RESP with rsp_err=1, rsp_timeout=1, rsp_rdata unchanged. PREADY=1 on the limit cycle completes normally.
- Not defined: no counter; ACCESS waits indefinitely; rsp_timeout tied 0.

## Test plan
- Write addr 0x010, data 0xA5, strb 1, PREADY=1 -> SETUP then ACCESS with PADDR=0x010, PWDATA=0xA5, PSTRB=1, PWRITE=1; rsp_valid in 3rd cycle after accept, rsp_err=0.
- Read addr 0x020, PREADY low 2 cycles then high with PRDATA=0x3C -> ACCESS lasts 3 cycles, signals stable, rsp_rdata=0x3C, PSTRB=0, PWDATA=0.
- Read addr 0x040 (> ADDR_LIMIT) -> PSEL stays 0, rsp_valid next cycle with rsp_err=1.
- Write with PSLVERR=1 at PREADY -> rsp_err=1, rsp_timeout=0; following read returns normally.
- Timeout build, TIMEOUT_CYCLES=4, PREADY held 0 -> after 4 wait cycles PSEL drops, rsp_err=1, rsp_timeout=1; non-timeout build stays in ACCESS.
- PRESETn low during ACCESS -> all outputs 0 immediately, no rsp_valid; after release a new command completes normally.
